// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage.
//
// Holds the fetch PC and issues in-order word requests to instruction memory
// over a request/grant port. Returned words are buffered with their PCs in a
// small FIFO, and the FIFO head is presented to the IF/ID register. A redirect
// flushes the FIFO and marks every in-flight response for discard.
//
// Parameters:
//   WordSize : PC / address width
//   ResetVec : first PC fetched after reset
//   Depth    : FIFO entries; also the cap on outstanding + buffered fetches (1..8)
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : IF/ID not accepting this cycle
//   redirect          : control-flow change, with target redirect_pc
//   imem_req/addr     : fetch request and its address (the fetch PC)
//   imem_gnt          : memory accepts the request this cycle
//   imem_rvalid/rdata : in-order response word
//   ins_valid/ins/pc_out : instruction and its PC for IF/ID
//   fetch_misalign    : sticky misaligned-redirect flag (IFETCH_MISALIGN_EN only)
//
// Optional feature macro: IFETCH_MISALIGN_EN. Without it the low two bits of
// redirect_pc are ignored and the target is forced word-aligned.
// ---------------------------------------------------------------------------
module ifetch #(
   parameter int WordSize = 32,
   parameter logic [WordSize-1:0] ResetVec = '0,
   parameter int Depth = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect,
   input  logic [WordSize-1:0] redirect_pc,
   output logic                imem_req,
   output logic [WordSize-1:0] imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [31:0]         imem_rdata,
   output logic                ins_valid,
   output logic [31:0]         ins,
   output logic [WordSize-1:0] pc_out
`ifdef IFETCH_MISALIGN_EN
   ,output logic               fetch_misalign
`endif
);

   localparam int CW = $clog2(Depth + 1);
   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [WordSize-1:0] fpc, rpc;
   logic [CW-1:0]       outst, disc, cnt;
   logic [PW-1:0]       rd_ptr, wr_ptr;
   logic [31:0]         word_q [Depth];
   logic [WordSize-1:0] pc_q [Depth];

   logic                grant, rsp, push, pop, fetch_block;
   logic [WordSize-1:0] load_pc;
   logic [CW:0]         inuse;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(Depth - 1)) return '0;
      else return p + PW'(1);
   endfunction

`ifdef IFETCH_MISALIGN_EN
   logic misalign;
   assign load_pc        = redirect_pc;
   assign fetch_block    = misalign;
   assign fetch_misalign = misalign;

   always_ff @(posedge clk) begin
      if (rst) misalign <= 1'b0;
      else if (redirect) misalign <= (redirect_pc[1:0] != 2'b00);
   end
`else
   logic unused_lowbits;
   assign unused_lowbits = ^redirect_pc[1:0];
   assign load_pc        = {redirect_pc[WordSize-1:2], 2'b00};
   assign fetch_block    = 1'b0;
`endif

   // Outstanding plus buffered fetches never exceed Depth, so a push always
   // finds a free slot even without a same-cycle pop.
   assign inuse     = {1'b0, cnt} + {1'b0, outst};
   assign imem_req  = !rst && !redirect && !fetch_block && (inuse < (CW + 1)'(Depth));
   assign imem_addr = fpc;
   assign grant     = imem_req && imem_gnt;

   // A response with nothing outstanding (e.g. a straggler from before reset)
   // is ignored entirely.
   assign rsp  = imem_rvalid && (outst != '0);
   assign push = rsp && (disc == '0) && !redirect;
   assign ins_valid = (cnt != '0);
   assign pop  = ins_valid && !stall;

   assign ins    = ins_valid ? word_q[rd_ptr] : '0;
   assign pc_out = ins_valid ? pc_q[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc    <= ResetVec;
         rpc    <= ResetVec;
         outst  <= '0;
         disc   <= '0;
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect) begin
         fpc    <= load_pc;
         rpc    <= load_pc;
         // Everything still in flight after this cycle's response is stale.
         outst  <= outst - CW'(rsp);
         disc   <= outst - CW'(rsp);
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         outst <= outst + CW'(grant) - CW'(rsp);
         if (rsp && (disc != '0)) disc <= disc - CW'(1);
         if (grant) fpc <= fpc + WordSize'(4);
         if (push) begin
            rpc    <= rpc + WordSize'(4);
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage: validity is tracked by cnt, so the payload needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr] <= imem_rdata;
         pc_q[wr_ptr]   <= rpc;
      end
   end

endmodule
